// File: rtl/oled_spi_if.sv
// SPI pin bundle of the PmodOLED link plus the decoded byte/pixel stream of the receiver.
interface oled_spi_if;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned PIX_W  = 16;
   localparam int unsigned IDX_W  = 13;

   logic              cs;
   logic              sclk;
   logic              sdin;
   logic              d_cn;
   logic              cmd_valid;
   logic [BYTE_W-1:0] cmd_byte;
   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;
   logic [IDX_W-1:0]  pix_index;
   logic              frame_done;
   logic              frame_err;

   modport master (
      output cs, sclk, sdin, d_cn,
      input  cmd_valid, cmd_byte, pix_valid, pix_data, pix_index, frame_done, frame_err
   );

   modport slave (
      input  cs, sclk, sdin, d_cn,
      output cmd_valid, cmd_byte, pix_valid, pix_data, pix_index, frame_done, frame_err
   );
endinterface

// File: rtl/oled_spi_rx.sv
// Mode-3 SPI slave for the PmodOLED pixel stream: splits command bytes from data
// bytes and reassembles RGB565 pixels with their linear index in the frame.
module oled_spi_rx #(
   parameter int unsigned SCREEN_W    = 96,
   parameter int unsigned SCREEN_H    = 64,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic     clk,
   input logic     resetn,
   oled_spi_if.slave spi
);

   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned PIX_W    = 16;
   localparam int unsigned IDX_W    = 13;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned NPIX     = SCREEN_W * SCREEN_H;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

   logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdin_sync, dcn_sync;
   logic                   cs_s, sclk_s, sdin_s, d_cn_s, sclk_prev;
   logic                   edge_c;

   logic [BYTE_W-1:0] shift_reg, shift_n;
   logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
   logic              byte_rdy, byte_rdy_n;
   logic [BYTE_W-1:0] byte_val, byte_val_n;
   logic              byte_dc, byte_dc_n;
   logic              hi_pending, hi_pending_n;
   logic [BYTE_W-1:0] hi_byte, hi_byte_n;
   logic [IDX_W-1:0]  pix_cnt, pix_cnt_n;

   logic              cmd_valid_q, cmd_valid_n;
   logic [BYTE_W-1:0] cmd_byte_q, cmd_byte_n;
   logic              pix_valid_q, pix_valid_n;
   logic [PIX_W-1:0]  pix_data_q, pix_data_n;
   logic [IDX_W-1:0]  pix_index_q, pix_index_n;
   logic              frame_done_q, frame_done_n;
   logic              frame_err_q, frame_err_n;

   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign sdin_s = sdin_sync[SYNC_STAGES-1];
   assign d_cn_s = dcn_sync[SYNC_STAGES-1];
   assign edge_c = sclk_s & ~sclk_prev;

   // Bit capture in one cycle, byte decode in the next, so outputs land one clk after the edge.
   always_comb begin
      shift_n      = shift_reg;
      bit_cnt_n    = bit_cnt;
      byte_rdy_n   = 1'b0;
      byte_val_n   = byte_val;
      byte_dc_n    = byte_dc;
      hi_pending_n = hi_pending;
      hi_byte_n    = hi_byte;
      pix_cnt_n    = pix_cnt;
      cmd_valid_n  = 1'b0;
      cmd_byte_n   = cmd_byte_q;
      pix_valid_n  = 1'b0;
      pix_data_n   = pix_data_q;
      pix_index_n  = pix_index_q;
      frame_done_n = 1'b0;
      frame_err_n  = 1'b0;

      if (cs_s) begin
         // bit_cnt clears here, so frame_err fires only on the first high cycle
         if (bit_cnt != '0) begin
            bit_cnt_n   = '0;
            frame_err_n = 1'b1;
         end
      end else if (edge_c) begin
         shift_n   = {shift_reg[BYTE_W-2:0], sdin_s};
         bit_cnt_n = bit_cnt + CNT_W'(1);
         if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
            byte_rdy_n = 1'b1;
            byte_val_n = shift_n;
            byte_dc_n  = d_cn_s;
         end
      end

      if (byte_rdy) begin
         if (!byte_dc) begin
            cmd_byte_n   = byte_val;
            cmd_valid_n  = 1'b1;
            hi_pending_n = 1'b0;
            pix_cnt_n    = '0;
         end else if (!hi_pending) begin
            hi_byte_n    = byte_val;
            hi_pending_n = 1'b1;
         end else begin
            pix_data_n   = {hi_byte, byte_val};
            pix_index_n  = pix_cnt;
            pix_valid_n  = 1'b1;
            hi_pending_n = 1'b0;
            if (pix_cnt == LAST_IDX) begin
               frame_done_n = 1'b1;
               pix_cnt_n    = '0;
            end else begin
               pix_cnt_n = pix_cnt + IDX_W'(1);
            end
         end
      end
   end

   // Synchronisers idle cs/sclk high so no edge or select is seen straight out of reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cs_sync      <= '1;
         sclk_sync    <= '1;
         sdin_sync    <= '0;
         dcn_sync     <= '0;
         sclk_prev    <= 1'b1;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         byte_rdy     <= 1'b0;
         byte_val     <= '0;
         byte_dc      <= 1'b0;
         hi_pending   <= 1'b0;
         hi_byte      <= '0;
         pix_cnt      <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_byte_q   <= '0;
         pix_valid_q  <= 1'b0;
         pix_data_q   <= '0;
         pix_index_q  <= '0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         cs_sync      <= {cs_sync[SYNC_STAGES-2:0], spi.cs};
         sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
         sdin_sync    <= {sdin_sync[SYNC_STAGES-2:0], spi.sdin};
         dcn_sync     <= {dcn_sync[SYNC_STAGES-2:0], spi.d_cn};
         sclk_prev    <= sclk_s;
         shift_reg    <= shift_n;
         bit_cnt      <= bit_cnt_n;
         byte_rdy     <= byte_rdy_n;
         byte_val     <= byte_val_n;
         byte_dc      <= byte_dc_n;
         hi_pending   <= hi_pending_n;
         hi_byte      <= hi_byte_n;
         pix_cnt      <= pix_cnt_n;
         cmd_valid_q  <= cmd_valid_n;
         cmd_byte_q   <= cmd_byte_n;
         pix_valid_q  <= pix_valid_n;
         pix_data_q   <= pix_data_n;
         pix_index_q  <= pix_index_n;
         frame_done_q <= frame_done_n;
         frame_err_q  <= frame_err_n;
      end
   end

   assign spi.cmd_valid  = cmd_valid_q;
   assign spi.cmd_byte   = cmd_byte_q;
   assign spi.pix_valid  = pix_valid_q;
   assign spi.pix_data   = pix_data_q;
   assign spi.pix_index  = pix_index_q;
   assign spi.frame_done = frame_done_q;
   assign spi.frame_err  = frame_err_q;

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed bench for oled_spi_rx: an event-queue model of the byte/pixel stream is
// checked against every output pulse, plus literal end-of-test expectations.
module tb_oled_spi_rx;

   localparam int unsigned TB_W  = 12;
   localparam int unsigned TB_H  = 8;
   localparam int unsigned NPIX  = TB_W * TB_H;
   localparam int unsigned SYNC  = 2;
   localparam time         CLK_P = 10;

   typedef enum logic [1:0] {EV_CMD, EV_PIX, EV_ERR} ev_kind_e;
   typedef struct {
      ev_kind_e    kind;
      logic [15:0] data;
      int          idx;
      bit          done;
   } ev_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #(CLK_P / 2) clk = ~clk;

   oled_spi_if spi ();

   oled_spi_rx #(
      .SCREEN_W   (TB_W),
      .SCREEN_H   (TB_H),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .spi   (spi)
   );

   ev_t  exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_pix   = 0;
   int   n_done  = 0;
   int   n_err   = 0;
   time  last_byte_t = 0;
   bit   chk_idx_eq  = 1'b0;
   logic prev_any    = 1'b0;

   // Stream model: what the receiver must report for each complete byte.
   int         m_cnt     = 0;
   bit         m_hi_pend = 1'b0;
   logic [7:0] m_hi      = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   function automatic logic [31:0] kind_bits(input ev_kind_e k);
      case (k)
         EV_CMD:  return 32'd4;
         EV_PIX:  return 32'd2;
         default: return 32'd1;
      endcase
   endfunction

   task automatic model_reset();
      m_cnt     = 0;
      m_hi_pend = 1'b0;
      m_hi      = 8'h00;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic dc);
      ev_t e;
      if (!dc) begin
         e.kind = EV_CMD; e.data = {8'h00, b}; e.idx = 0; e.done = 1'b0;
         exp_q.push_back(e);
         m_hi_pend = 1'b0;
         m_cnt     = 0;
      end else if (!m_hi_pend) begin
         m_hi      = b;
         m_hi_pend = 1'b1;
      end else begin
         e.kind = EV_PIX; e.data = {m_hi, b}; e.idx = m_cnt; e.done = (m_cnt == NPIX - 1);
         exp_q.push_back(e);
         m_cnt     = (m_cnt + 1) % NPIX;
         m_hi_pend = 1'b0;
      end
   endtask

   task automatic model_err();
      ev_t e;
      e.kind = EV_ERR; e.data = 16'h0000; e.idx = 0; e.done = 1'b0;
      exp_q.push_back(e);
   endtask

   // sclk = clk/4, data changes on the falling edge, MSB first; sclk is left high.
   task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         @(negedge clk);
         spi.sclk = 1'b0;
         spi.sdin = b[i];
         spi.d_cn = dc;
         repeat (2) @(negedge clk);
         spi.sclk = 1'b1;
         if (i == 0) begin
            last_byte_t = $time;
            model_byte(b, dc);
         end
         @(negedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic dc);
      send_bits(b, dc, 8);
   endtask

   task automatic wait_idle();
      int cnt = 0;
      while (exp_q.size() != 0 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d expected events still pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   // Every output pulse is matched against the head of the expected-event queue.
   always @(negedge clk) begin
      logic any;
      ev_t  e;
      any = spi.cmd_valid | spi.pix_valid | spi.frame_err | spi.frame_done;
      if (any) begin
         check("pulse_width", 32'(prev_any), 32'd0);
         if (spi.pix_valid)  n_pix++;
         if (spi.frame_done) n_done++;
         if (spi.frame_err)  n_err++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: got cmd=%b pix=%b err=%b done=%b, expected no pulse",
                     spi.cmd_valid, spi.pix_valid, spi.frame_err, spi.frame_done);
         end else begin
            e = exp_q.pop_front();
            check("event_kind", {29'd0, spi.cmd_valid, spi.pix_valid, spi.frame_err}, kind_bits(e.kind));
            check("frame_done", 32'(spi.frame_done), 32'(e.done));
            if (e.kind == EV_CMD) begin
               check("cmd_byte", 32'(spi.cmd_byte), 32'(e.data[7:0]));
               check("cmd_latency", 32'(($time - last_byte_t) / CLK_P), SYNC + 2);
            end else if (e.kind == EV_PIX) begin
               check("pix_data", 32'(spi.pix_data), 32'(e.data));
               check("pix_index", 32'(spi.pix_index), 32'(e.idx));
               check("pix_latency", 32'(($time - last_byte_t) / CLK_P), SYNC + 2);
               if (chk_idx_eq) check("index_eq_data", 32'(spi.pix_index), 32'(spi.pix_data[12:0]));
            end
         end
      end
      prev_any <= any;
   end

   initial begin
      #(CLK_P * 50000);
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      spi.cs   = 1'b1;
      spi.sclk = 1'b1;
      spi.sdin = 1'b0;
      spi.d_cn = 1'b0;
      resetn   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd_valid",  32'(spi.cmd_valid),  32'd0);
      check("rst_cmd_byte",   32'(spi.cmd_byte),   32'd0);
      check("rst_pix_valid",  32'(spi.pix_valid),  32'd0);
      check("rst_pix_data",   32'(spi.pix_data),   32'd0);
      check("rst_pix_index",  32'(spi.pix_index),  32'd0);
      check("rst_frame_done", 32'(spi.frame_done), 32'd0);
      check("rst_frame_err",  32'(spi.frame_err),  32'd0);
      resetn = 1'b1;
      model_reset();
      repeat (4) @(negedge clk);
      spi.cs = 1'b0;
      repeat (4) @(negedge clk);

      // single command
      send_byte(8'h15, 1'b0);
      wait_idle();
      check("t1_cmd_byte", 32'(spi.cmd_byte), 32'h15);
      check("t1_no_pix",   32'(n_pix),        32'd0);

      // command then two pixels
      send_byte(8'hA0, 1'b0);
      send_byte(8'hF8, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h07, 1'b1);
      send_byte(8'hE0, 1'b1);
      wait_idle();
      check("t2_cmd_byte",  32'(spi.cmd_byte),  32'hA0);
      check("t2_pix_data",  32'(spi.pix_data),  32'h07E0);
      check("t2_pix_index", 32'(spi.pix_index), 32'd1);
      check("t2_pix_count", 32'(n_pix),         32'd2);
      check("t2_no_done",   32'(n_done),        32'd0);

      // full frame, pixel i carries value i, then index wraps to 0
      send_byte(8'h5C, 1'b0);
      chk_idx_eq = 1'b1;
      for (int i = 0; i < NPIX; i++) begin
         send_byte(8'(i >> 8), 1'b1);
         send_byte(8'(i), 1'b1);
      end
      wait_idle();
      chk_idx_eq = 1'b0;
      check("t3_last_index", 32'(spi.pix_index), 32'(NPIX - 1));
      check("t3_last_data",  32'(spi.pix_data),  32'(NPIX - 1));
      check("t3_done_count", 32'(n_done),        32'd1);
      send_byte(8'hBE, 1'b1);
      send_byte(8'hEF, 1'b1);
      wait_idle();
      check("t3_wrap_index", 32'(spi.pix_index), 32'd0);
      check("t3_wrap_data",  32'(spi.pix_data),  32'hBEEF);

      // cs raised after 5 bits, then a clean pixel continuing the count
      send_bits(8'h3C, 1'b1, 5);
      @(negedge clk);
      spi.cs = 1'b1;
      model_err();
      repeat (6) @(negedge clk);
      spi.cs = 1'b0;
      repeat (4) @(negedge clk);
      send_byte(8'hAB, 1'b1);
      send_byte(8'hCD, 1'b1);
      wait_idle();
      check("t4_err_count", 32'(n_err),         32'd1);
      check("t4_pix_data",  32'(spi.pix_data),  32'hABCD);
      check("t4_pix_index", 32'(spi.pix_index), 32'd1);
      check("t4_done_count", 32'(n_done),       32'd1);

      // a command discards a half pixel and restarts the index
      send_byte(8'h12, 1'b1);
      send_byte(8'h75, 1'b0);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      wait_idle();
      check("t5_cmd_byte",  32'(spi.cmd_byte),  32'h75);
      check("t5_pix_data",  32'(spi.pix_data),  32'h3456);
      check("t5_pix_index", 32'(spi.pix_index), 32'd0);

      // one-clk reset mid-byte drops the byte without frame_err
      send_bits(8'hC3, 1'b1, 4);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
      check("t6_rst_pix_data", 32'(spi.pix_data), 32'd0);
      repeat (4) @(negedge clk);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h5A, 1'b1);
      wait_idle();
      check("t6_pix_data",  32'(spi.pix_data),  32'h5A5A);
      check("t6_pix_index", 32'(spi.pix_index), 32'd0);
      check("t6_err_count", 32'(n_err),         32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- SPI receiver for the 96x64 PmodOLED pixel stream (cs, sdin, sclk, d_cn), i.e. the slave end of the link the OLED driver transmits on.
- Deserialises bytes, separates command from data using d_cn, and reassembles RGB565 pixels tagged with a 13-bit pixel index.
- Used on-board as a frame-capture/loopback monitor and in simulation as the checker for the display path.

Parameters:
- SCREEN_W, 96, pixels per row.
- SCREEN_H, 64, rows per frame.
- SYNC_STAGES, 2, flops per input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock (100 MHz); sclk must be at most clk/4.
- resetn  in  1  synchronous, active-low reset.
- cs  in  1  SPI chip select, active low, asynchronous to clk.
- sclk  in  1  SPI clock, mode 3 (idles high, data sampled on rising edge).
- sdin  in  1  SPI data, MSB first.
- d_cn  in  1  1 = data byte, 0 = command byte.
- cmd_valid  out  1  one-cycle pulse, command byte received.
- cmd_byte  out  8  last command byte; holds until the next command.
- pix_valid  out  1  one-cycle pulse, pixel assembled.
- pix_data  out  16  RGB565 value, first data byte in [15:8]; holds until the next pixel.
- pix_index  out  13  index of pix_data, 0..SCREEN_W*SCREEN_H-1.
- frame_done  out  1  one-cycle pulse, asserted together with pix_valid of the last pixel.
- frame_err  out  1  one-cycle pulse, cs deasserted mid-byte.

Behaviour:
- Synchronisers: cs, sclk, sdin and d_cn each pass through SYNC_STAGES flops; all logic uses the synchronised copies (_s).
- Rising-edge detect: sclk_s == 1 and the previous sclk_s == 0.
- Bit capture: an edge is accepted only if cs_s == 0 in the same cycle (cs high wins).
- On an accepted edge: shift_reg <= {shift_reg[6:0], sdin_s}; bit_cnt increments (3 bits).
- Byte complete: on the 8th accepted edge (bit_cnt == 7), bit_cnt wraps to 0. The byte type is d_cn_s sampled on that same edge.
- Output latency: cmd_valid / pix_valid are registered and rise 1 clk after the edge-detect cycle, i.e. SYNC_STAGES+2 clk cycles after sclk first goes high on the pin.
- Command byte:
  - cmd_byte <= byte; cmd_valid pulses.
  - hi_pending cleared, any half pixel discarded.
  - pix_cnt <= 0, so the next pixel is index 0 (the driver re-sends window commands before each frame).
- Data byte, hi_pending == 0: hi_byte <= byte; hi_pending <= 1; no output.
- Data byte, hi_pending == 1:
  - pix_data <= {hi_byte, byte}; pix_index <= pix_cnt; pix_valid pulses; hi_pending <= 0.
  - If pix_cnt == SCREEN_W*SCREEN_H-1: frame_done pulses in the same cycle and pix_cnt wraps to 0; otherwise pix_cnt increments.
- cs_s high with bit_cnt != 0:
  - Partial byte discarded; bit_cnt <= 0; frame_err pulses once, on the first cycle cs_s is high.
  - hi_pending and pix_cnt are kept, so a pixel may straddle a cs deassertion at a byte boundary.
- cs_s high with bit_cnt == 0: no effect.
- Reset (resetn == 0 at a clk edge):
  - All outputs 0.
  - shift_reg, bit_cnt, hi_pending, hi_byte and pix_cnt cleared.
  - Synchroniser flops reset to 1 for cs and sclk (idle), 0 for sdin and d_cn.
  - Reset mid-byte drops the byte with no frame_err.
  - The first edge after reset release is counted only if it follows a synchronised low sclk.
- Pulse width: cmd_valid, pix_valid, frame_done and frame_err are never high for more than 1 consecutive clk.
- Back-to-back bytes: at sclk = clk/4, consecutive pixel pulses are at least 32 clk apart; no buffering needed.

Test Plan:
- Reset, then send command 0x15 with d_cn=0 -> cmd_valid one pulse; cmd_byte=0x15; pix_valid stays 0; cmd_valid rises SYNC_STAGES+2 clk after the 8th sclk rising edge.
- Command 0xA0, then data 0xF8, 0x00, 0x07, 0xE0 -> two pix_valid pulses: (index 0, 0xF800), then (index 1, 0x07E0); frame_done 0.
- Full frame: command, then 12288 data bytes of value i[15:0] for pixel i -> 6144 pix_valid pulses with pix_index == pix_data[12:0]; frame_done high only with index 6143; next pixel index 0.
- cs raised after 5 bits of a data byte, then a full byte 0xAB -> frame_err one pulse; partial byte ignored; 0xAB taken as hi byte; frame_done not affected.
- Data 0x12, then command 0x75, then data 0x34, 0x56 -> cmd_valid for 0x75; one pixel 0x3456 at index 0 (0x12 discarded).
- resetn low for 1 clk after 4 bits, then byte 0x5A as data, then 0x5A again -> no frame_err; one pixel 0x5A5A at index 0.
